vliw_decode_latch: RTL and testbench

- Decode-side pipeline latch directly downstream of the instruction fetch stage.
- Each cycle it captures the 128-bit VLIW bundle from fetch and splits it into four 32-bit slots. It extracts per-slot register fields and detects load-use hazards against the bundle it already holds.
- On a hazard it drives dec_stall back to fetch and inserts a bubble bundle into decode. It also keeps bubble and issued-bundle performance counters.

---
 rtl/vliw_decode_latch.sv | 135 +++++++++++++
 tb/tb_vliw_decode_latch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vliw_decode_latch.sv
// Decode-side latch for 128-bit VLIW bundles: splits slots, extracts register fields,
// detects load-use hazards against the held bundle and inserts a single bubble per hazard.
module vliw_decode_latch #(
  parameter int NSLOT  = 4,
  parameter int SLOT_W = 32,
  parameter int REG_W  = 6,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [NSLOT*SLOT_W-1:0] inst,
  output logic                    dec_stall,
  output logic [NSLOT*SLOT_W-1:0] d_inst,
  output logic                    d_valid,
  output logic [NSLOT*REG_W-1:0]  d_rd,
  output logic [NSLOT*REG_W-1:0]  d_rs1,
  output logic [NSLOT*REG_W-1:0]  d_rs2,
  output logic [NSLOT-1:0]        d_ldmask,
  output logic [CNT_W-1:0]        bubble_cnt,
  output logic [CNT_W-1:0]        issue_cnt
);

  localparam int BUN_W = NSLOT * SLOT_W;
  localparam int FLD_W = NSLOT * REG_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [2:0] OP_ALUR  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_BR    = 3'b101;
  localparam logic [2:0] OP_JUMP  = 3'b111;

  logic [SLOT_W-1:0] w_word;
  logic [2:0]        w_op;
  logic [FLD_W-1:0]  w_rd_pk, w_rs1_pk, w_rs2_pk;
  logic [NSLOT-1:0]  w_ldmask;
  logic [NSLOT-1:0]  w_rs1_use, w_rs2_use;
  logic              w_hazard;

  logic [BUN_W-1:0]  r_inst_p1;
  logic              r_vld_p1;
  logic [FLD_W-1:0]  r_rd_p1, r_rs1_p1, r_rs2_p1;
  logic [NSLOT-1:0]  r_ldmask_p1;
  logic [CNT_W-1:0]  r_bubble_cnt, r_issue_cnt;

  // Stage p0: slot split, field extraction and operand-read classification of the incoming bundle
  always_comb begin
    w_word    = '0;
    w_op      = '0;
    w_rd_pk   = '0;
    w_rs1_pk  = '0;
    w_rs2_pk  = '0;
    w_ldmask  = '0;
    w_rs1_use = '0;
    w_rs2_use = '0;
    for (int s = 0; s < NSLOT; s++) begin
      w_word = inst[BUN_W-1-s*SLOT_W -: SLOT_W];
      w_op   = w_word[2:0];
      w_rd_pk[(NSLOT-s)*REG_W-1 -: REG_W]  = w_word[11:6];
      w_rs1_pk[(NSLOT-s)*REG_W-1 -: REG_W] = w_word[17:12];
      w_rs2_pk[(NSLOT-s)*REG_W-1 -: REG_W] = w_word[23:18];
      w_ldmask[NSLOT-1-s] = (w_op == OP_LOAD);
      if (w_word != '0) begin
        unique case (w_op)
          OP_ALUR, OP_STORE, OP_BR: begin
            w_rs1_use[s] = 1'b1;
            w_rs2_use[s] = 1'b1;
          end
          OP_JUMP: w_rs1_use[s] = w_word[3];
          default: w_rs1_use[s] = 1'b1;
        endcase
      end
    end
  end

  // Any load in the held bundle (rd != r0) feeding any read of the incoming bundle
  always_comb begin
    w_hazard = 1'b0;
    for (int l = 0; l < NSLOT; l++) begin
      if (r_vld_p1 && r_ldmask_p1[NSLOT-1-l] && (r_rd_p1[(NSLOT-l)*REG_W-1 -: REG_W] != '0)) begin
        for (int s = 0; s < NSLOT; s++) begin
          if ((w_rs1_use[s] && (w_rs1_pk[(NSLOT-s)*REG_W-1 -: REG_W] == r_rd_p1[(NSLOT-l)*REG_W-1 -: REG_W])) ||
              (w_rs2_use[s] && (w_rs2_pk[(NSLOT-s)*REG_W-1 -: REG_W] == r_rd_p1[(NSLOT-l)*REG_W-1 -: REG_W])))
            w_hazard = 1'b1;
        end
      end
    end
  end

  assign dec_stall = w_hazard & ~flush & ~rst;

  // Stage p1: decode latch and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_p1    <= '0;
      r_vld_p1     <= 1'b0;
      r_rd_p1      <= '0;
      r_rs1_p1     <= '0;
      r_rs2_p1     <= '0;
      r_ldmask_p1  <= '0;
      r_bubble_cnt <= '0;
      r_issue_cnt  <= '0;
    end else if (!stall) begin
      if (flush || w_hazard) begin
        r_inst_p1   <= '0;
        r_vld_p1    <= 1'b0;
        r_rd_p1     <= '0;
        r_rs1_p1    <= '0;
        r_rs2_p1    <= '0;
        r_ldmask_p1 <= '0;
        if (!flush) r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end else begin
        r_inst_p1   <= inst;
        r_vld_p1    <= 1'b1;
        r_rd_p1     <= w_rd_pk;
        r_rs1_p1    <= w_rs1_pk;
        r_rs2_p1    <= w_rs2_pk;
        r_ldmask_p1 <= w_ldmask;
        r_issue_cnt <= r_issue_cnt + CNT_ONE;
      end
    end
  end

  assign d_inst     = r_inst_p1;
  assign d_valid    = r_vld_p1;
  assign d_rd       = r_rd_p1;
  assign d_rs1      = r_rs1_p1;
  assign d_rs2      = r_rs2_p1;
  assign d_ldmask   = r_ldmask_p1;
  assign bubble_cnt = r_bubble_cnt;
  assign issue_cnt  = r_issue_cnt;

endmodule

// File: tb/tb_vliw_decode_latch.sv
// Bench for vliw_decode_latch: directed load-use scenarios followed by randomized traffic,
// all checked against an instruction-level reference model.
module tb_vliw_decode_latch;

  logic         clk = 1'b0;
  logic         rst, stall, flush;
  logic [127:0] inst;
  logic         dec_stall, d_valid;
  logic [127:0] d_inst;
  logic [23:0]  d_rd, d_rs1, d_rs2;
  logic [3:0]   d_ldmask;
  logic [31:0]  bubble_cnt, issue_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit           m_valid;
  logic [127:0] m_bun;
  logic [31:0]  m_bub, m_iss;
  bit           last_ds;

  vliw_decode_latch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .inst(inst),
    .dec_stall(dec_stall), .d_inst(d_inst), .d_valid(d_valid),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_ldmask(d_ldmask),
    .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] slotw(input logic [127:0] b, input int s);
    return b[127-32*s -: 32];
  endfunction

  function automatic bit is_load(input logic [31:0] w);
    return w[2:0] == 3'b011;
  endfunction

  // does instruction word w read register r under the ISA operand rules
  function automatic bit reads(input logic [31:0] w, input logic [5:0] r);
    bit r1, r2;
    if (w == 32'd0) return 1'b0;
    r1 = (w[2:0] == 3'b111) ? w[3] : 1'b1;
    r2 = (w[2:0] == 3'b001) || (w[2:0] == 3'b100) || (w[2:0] == 3'b101);
    return (r1 && (w[17:12] == r)) || (r2 && (w[23:18] == r));
  endfunction

  function automatic bit hazard(input logic [127:0] nb);
    logic [31:0] w;
    if (!m_valid) return 1'b0;
    for (int l = 0; l < 4; l++) begin
      w = slotw(m_bun, l);
      if (is_load(w) && (w[11:6] != 6'd0))
        for (int s = 0; s < 4; s++)
          if (reads(slotw(nb, s), w[11:6])) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    logic [23:0] e_rd, e_rs1, e_rs2;
    logic [3:0]  e_ld;
    logic [31:0] w;
    for (int s = 0; s < 4; s++) begin
      w = slotw(m_bun, s);
      e_rd[23-6*s -: 6]  = w[11:6];
      e_rs1[23-6*s -: 6] = w[17:12];
      e_rs2[23-6*s -: 6] = w[23:18];
      e_ld[3-s]          = is_load(w);
    end
    chk("d_inst", d_inst, m_bun);
    chk("d_valid", 128'(d_valid), 128'(m_valid));
    chk("d_rd", 128'(d_rd), 128'(e_rd));
    chk("d_rs1", 128'(d_rs1), 128'(e_rs1));
    chk("d_rs2", 128'(d_rs2), 128'(e_rs2));
    chk("d_ldmask", 128'(d_ldmask), 128'(e_ld));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bub));
    chk("issue_cnt", 128'(issue_cnt), 128'(m_iss));
  endtask

  // one clock: drive inputs, check dec_stall, advance model, check latched outputs
  task automatic cycle(input bit r, input bit s, input bit f, input logic [127:0] b);
    bit haz;
    rst = r; stall = s; flush = f; inst = b;
    #2;
    haz     = hazard(b);
    last_ds = !r && haz && !f;
    chk("dec_stall", 128'(dec_stall), 128'(last_ds));
    if (r) begin
      m_valid = 1'b0; m_bun = '0; m_bub = '0; m_iss = '0;
    end else if (!s) begin
      if (f || haz) begin
        m_valid = 1'b0; m_bun = '0;
        if (!f) m_bub = m_bub + 32'd1;
      end else begin
        m_valid = 1'b1; m_bun = b; m_iss = m_iss + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  function automatic logic [31:0] rnd_slot();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(7) == 0) return 32'd0;
    w[11:6]  = 6'($urandom_range(7));
    w[17:12] = 6'($urandom_range(7));
    w[23:18] = 6'($urandom_range(7));
    if ($urandom_range(2) == 0) w[2:0] = 3'b011;
    return w;
  endfunction

  function automatic logic [127:0] rnd_bundle();
    return {rnd_slot(), rnd_slot(), rnd_slot(), rnd_slot()};
  endfunction

  logic [127:0] LD5, ALU5, LD0, ALU0, LD7, JMP7N, JMP7Y, rb;
  logic [31:0]  iss_before, bub_before;
  bit           rr, rs, rf;

  initial begin
    LD5   = {32'h0000_0143, 96'd0};
    ALU5  = {64'd0, 32'h0000_5001, 32'd0};
    LD0   = {32'h0000_0003, 96'd0};
    ALU0  = {32'd0, 32'h0000_0001, 64'd0};
    LD7   = {32'd0, 32'h0000_01C3, 64'd0};
    JMP7N = {96'd0, 32'h0000_7007};
    JMP7Y = {96'd0, 32'h0000_700F};
    m_valid = 1'b0; m_bun = '0; m_bub = '0; m_iss = '0; last_ds = 1'b0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; inst = '1;
    #1;

    // reset with all-ones bundle
    cycle(1, 0, 0, '1);
    cycle(1, 0, 0, '1);
    chk("rst_d_valid", 128'(d_valid), 128'd0);
    chk("rst_issue", 128'(issue_cnt), 128'd0);

    // load-use: one bubble then reissue
    cycle(0, 0, 0, LD5);
    cycle(0, 0, 0, ALU5);
    chk("lu_bubble", 128'(bubble_cnt), 128'd1);
    chk("lu_valid", 128'(d_valid), 128'd0);
    cycle(0, 0, 0, ALU5);
    chk("lu_reissue", 128'(issue_cnt), 128'd2);
    chk("lu_valid2", 128'(d_valid), 128'd1);

    // r0 never hazards
    cycle(0, 0, 0, LD0);
    cycle(0, 0, 0, ALU0);
    chk("r0_bubble", 128'(bubble_cnt), 128'd1);

    // jump without rs1 read, then with
    cycle(0, 0, 0, LD7);
    cycle(0, 0, 0, JMP7N);
    chk("jmp_nord_bubble", 128'(bubble_cnt), 128'd1);
    cycle(0, 0, 0, LD7);
    cycle(0, 0, 0, JMP7Y);
    chk("jmp_rd_bubble", 128'(bubble_cnt), 128'd2);

    // flush beats hazard
    cycle(0, 0, 0, LD5);
    iss_before = issue_cnt; bub_before = bubble_cnt;
    cycle(0, 0, 1, ALU5);
    chk("fl_bubble", 128'(bubble_cnt), 128'(bub_before));
    chk("fl_issue", 128'(issue_cnt), 128'(iss_before));

    // stall holds everything, then rst during stall
    cycle(0, 0, 0, LD5);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, rnd_bundle());
    chk("stall_hold", d_inst, LD5);
    cycle(1, 1, 0, rnd_bundle());
    chk("rst_in_stall", 128'(d_valid), 128'd0);

    // counter wrap
    cycle(0, 0, 0, 128'd0);
    force dut.r_issue_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_issue_cnt;
    m_iss = 32'hFFFF_FFFF;
    chk("wrap_pre", 128'(issue_cnt), 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    cycle(0, 0, 0, 128'd0);
    chk("wrap_post", 128'(issue_cnt), 128'd0);

    // randomized traffic; fetch re-presents the bundle while dec_stall is high
    rb = rnd_bundle();
    for (int i = 0; i < 400; i++) begin
      if (!last_ds) rb = rnd_bundle();
      rr = ($urandom_range(49) == 0);
      rs = ($urandom_range(9) == 0);
      rf = ($urandom_range(9) == 0);
      cycle(rr, rs, rf, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
